// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
// Holds the FSM encoding, digit limits and a BCD step helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [3:0] DIG_MAX_UNITS = 4'd9;
    localparam logic [3:0] DIG_MAX_TENS  = 4'd5;

    // Value the chained digit counters take after one tick.
    // Lets the display register load the post-tick count on the tick edge.
    function automatic logic [15:0] bcd_step(input logic [15:0] v);
        logic [3:0] s0;
        logic [3:0] s1;
        logic [3:0] m0;
        logic [3:0] m1;
        {m1, m0, s1, s0} = v;
        if (s0 < DIG_MAX_UNITS) begin
            s0 = s0 + 4'd1;
        end else begin
            s0 = 4'd0;
            if (s1 < DIG_MAX_TENS) begin
                s1 = s1 + 4'd1;
            end else begin
                s1 = 4'd0;
                if (m0 < DIG_MAX_UNITS) begin
                    m0 = m0 + 4'd1;
                end else begin
                    m0 = 4'd0;
                    if (m1 < DIG_MAX_TENS) m1 = m1 + 4'd1;
                    else                   m1 = 4'd0;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit wrapping at MAX.
// carry is combinational: high when inc arrives at MAX.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = DIG_MAX_UNITS
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       carry
);

    assign carry = inc && (digit == MAX);

    // Digit register: clear wins, otherwise step and wrap at MAX.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            digit <= 4'd0;
        end else if (clr) begin
            digit <= 4'd0;
        end else if (inc) begin
            digit <= (digit == MAX) ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch with lap freeze and display scan clock.
// FSM, prescaler, scan divider and lap register live here.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int SEC_DIV  = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Key_StartStop,
    input  logic        Key_Clear,
    input  logic        Key_Lap,
    output logic [15:0] All,
    output logic        Clk1,
    output logic        Running,
    output logic        Lap_Active,
    output logic        Wrap
);

    localparam int PW = $clog2(SEC_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SEC_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV / 2 - 1);

    state_t        state;
    state_t        next_state;
    logic          do_clear;
    logic          capture;
    logic          counting;
    logic          tick;
    logic [PW-1:0] presc;
    logic [SW-1:0] scan;
    logic [15:0]   live;
    logic [15:0]   live_next;
    logic [15:0]   lap_reg;
    logic [15:0]   lap_next;
    logic [3:0]    s0;
    logic [3:0]    s1;
    logic [3:0]    m0;
    logic [3:0]    m1;
    logic          c0;
    logic          c1;
    logic          c2;
    logic          c3;

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PRESC_LAST);
    assign live     = {m1, m0, s1, s0};

    // Next-state decode; keys not valid in a state drop out of priority.
    always_comb begin
        next_state = state;
        do_clear   = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (Key_StartStop) next_state = RUN;
            end
            RUN: begin
                if (Key_StartStop) begin
                    next_state = PAUSE;
                end else if (Key_Lap) begin
                    next_state = LAP;
                    capture    = 1'b1;
                end
            end
            LAP: begin
                if (Key_StartStop)  next_state = PAUSE;
                else if (Key_Lap)   next_state = RUN;
            end
            PAUSE: begin
                if (Key_Clear) begin
                    next_state = IDLE;
                    do_clear   = 1'b1;
                end else if (Key_StartStop) begin
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= next_state;
    end

    // Seconds prescaler: counts while running, holds in pause, zero in idle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            presc <= '0;
        end else if (do_clear || state == IDLE) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else if (counting) begin
            presc <= presc + 1'b1;
        end
    end

    bcd_digit_counter #(.MAX(DIG_MAX_UNITS)) u_s0 (
        .Clk(Clk), .Rst(Rst), .inc(tick), .clr(do_clear),
        .digit(s0), .carry(c0)
    );
    bcd_digit_counter #(.MAX(DIG_MAX_TENS)) u_s1 (
        .Clk(Clk), .Rst(Rst), .inc(c0), .clr(do_clear),
        .digit(s1), .carry(c1)
    );
    bcd_digit_counter #(.MAX(DIG_MAX_UNITS)) u_m0 (
        .Clk(Clk), .Rst(Rst), .inc(c1), .clr(do_clear),
        .digit(m0), .carry(c2)
    );
    bcd_digit_counter #(.MAX(DIG_MAX_TENS)) u_m1 (
        .Clk(Clk), .Rst(Rst), .inc(c2), .clr(do_clear),
        .digit(m1), .carry(c3)
    );

    assign live_next = do_clear ? 16'h0000 :
                       tick     ? bcd_step(live) : live;
    assign lap_next  = capture ? live_next : lap_reg;

    // Lap register grabs the post-edge count when entering LAP.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)          lap_reg <= 16'h0000;
        else if (capture) lap_reg <= live_next;
    end

    // Display register loads what the digits will hold after this edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            All <= 16'h0000;
        end else if (next_state == LAP) begin
            All <= lap_next;
        end else begin
            All <= live_next;
        end
    end

    // Rollover pulse follows the carry out of the top digit.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) Wrap <= 1'b0;
        else     Wrap <= c3;
    end

    // Free-running scan divider toggling Clk1 every SCAN_DIV/2 cycles.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            scan <= '0;
            Clk1 <= 1'b0;
        end else if (scan == SCAN_LAST) begin
            scan <= '0;
            Clk1 <= ~Clk1;
        end else begin
            scan <= scan + 1'b1;
        end
    end

    assign Running    = counting;
    assign Lap_Active = (state == LAP);

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with SEC_DIV=4, SCAN_DIV=4.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_stopwatch_bcd;

    logic        Clk;
    logic        Rst;
    logic        Key_StartStop;
    logic        Key_Clear;
    logic        Key_Lap;
    logic [15:0] All;
    logic        Clk1;
    logic        Running;
    logic        Lap_Active;
    logic        Wrap;

    int checks   = 0;
    int failures = 0;

    stopwatch_bcd #(.SEC_DIV(4), .SCAN_DIV(4)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Key_StartStop(Key_StartStop),
        .Key_Clear(Key_Clear),
        .Key_Lap(Key_Lap),
        .All(All),
        .Clk1(Clk1),
        .Running(Running),
        .Lap_Active(Lap_Active),
        .Wrap(Wrap)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Key high for exactly the next rising edge.
    task automatic press(input logic ss, input logic cl, input logic lp);
        Key_StartStop = ss;
        Key_Clear     = cl;
        Key_Lap       = lp;
        step(1);
        Key_StartStop = 1'b0;
        Key_Clear     = 1'b0;
        Key_Lap       = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        step(2);
        Rst = 1'b0;
    endtask

    initial begin
        Rst           = 1'b1;
        Key_StartStop = 1'b0;
        Key_Clear     = 1'b0;
        Key_Lap       = 1'b0;

        // Reset state and scan clock.
        step(3);
        check("rst_all", All, 16'h0000);
        check("rst_clk1", {15'd0, Clk1}, 16'd0);
        check("rst_running", {15'd0, Running}, 16'd0);
        check("rst_lap", {15'd0, Lap_Active}, 16'd0);
        check("rst_wrap", {15'd0, Wrap}, 16'd0);
        Rst = 1'b0;
        step(1);
        check("clk1_e1", {15'd0, Clk1}, 16'd0);
        step(1);
        check("clk1_e2", {15'd0, Clk1}, 16'd1);
        step(1);
        check("clk1_e3", {15'd0, Clk1}, 16'd1);
        step(1);
        check("clk1_e4", {15'd0, Clk1}, 16'd0);

        // Idle ignores Clear and Lap.
        press(1'b0, 1'b1, 1'b1);
        check("idle_keys_run", {15'd0, Running}, 16'd0);

        // Counting: 40 cycles = 10 s.
        press(1'b1, 1'b0, 1'b0);
        check("start_running", {15'd0, Running}, 16'd1);
        step(3);
        check("pre_tick", All, 16'h0000);
        step(1);
        check("first_tick", All, 16'h0001);
        step(36);
        check("count_10s", All, 16'h0010);
        check("count_running", {15'd0, Running}, 16'd1);
        press(1'b1, 1'b0, 1'b0);
        check("pause_running", {15'd0, Running}, 16'd0);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("pause_hold", All, 16'h0010);
        end

        // Clear beats StartStop in PAUSE.
        press(1'b1, 1'b1, 1'b0);
        check("clr_all", All, 16'h0000);
        check("clr_running", {15'd0, Running}, 16'd0);
        step(8);
        check("clr_idle_hold", All, 16'h0000);

        // Clear during RUN is ignored.
        press(1'b1, 1'b0, 1'b0);
        step(20);
        check("run_5s", All, 16'h0005);
        press(1'b0, 1'b1, 1'b0);
        check("run_clr_ign", All, 16'h0005);
        check("run_clr_run", {15'd0, Running}, 16'd1);
        step(3);
        check("run_clr_cnt", All, 16'h0006);

        // Lap freeze and release.
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        step(20);
        check("lap_pre", All, 16'h0005);
        press(1'b0, 1'b0, 1'b1);
        check("lap_active", {15'd0, Lap_Active}, 16'd1);
        check("lap_running", {15'd0, Running}, 16'd1);
        check("lap_cap", All, 16'h0005);
        for (int i = 0; i < 12; i++) begin
            step(1);
            check("lap_hold", All, 16'h0005);
        end
        press(1'b0, 1'b0, 1'b1);
        check("lap_exit_all", All, 16'h0008);
        check("lap_exit_flag", {15'd0, Lap_Active}, 16'd0);
        check("lap_exit_run", {15'd0, Running}, 16'd1);

        // Wrap at 59:59.
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        step(14396);
        check("wrap_5959", All, 16'h5959);
        check("wrap_low0", {15'd0, Wrap}, 16'd0);
        step(3);
        check("wrap_low1", {15'd0, Wrap}, 16'd0);
        step(1);
        check("wrap_zero", All, 16'h0000);
        check("wrap_pulse", {15'd0, Wrap}, 16'd1);
        step(1);
        check("wrap_once", {15'd0, Wrap}, 16'd0);

        // Mid-run asynchronous reset at 01:23 (83 s).
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        step(332);
        check("mid_0123", All, 16'h0123);
        #2;
        Rst = 1'b1;
        #1;
        check("mid_rst_all", All, 16'h0000);
        check("mid_rst_run", {15'd0, Running}, 16'd0);
        check("mid_rst_clk1", {15'd0, Clk1}, 16'd0);
        step(1);
        Rst = 1'b0;
        step(8);
        check("mid_idle_run", {15'd0, Running}, 16'd0);
        check("mid_idle_all", All, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL have parameter SEC_DIV, default 50000000: Clk cycles per one-second count tick, at least 2.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: Clk cycles per Clk1 period, even, at least 2.
REQ-003 SHALL have port Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port Key_StartStop, input, 1 bit: single-cycle pulse, synchronous and debounced upstream.
REQ-006 SHALL have port Key_Clear, input, 1 bit: single-cycle pulse.
REQ-007 SHALL have port Key_Lap, input, 1 bit: single-cycle pulse.
REQ-008 SHALL have port All, output, 16 bits: display value {M1,M0,S1,S0}, one BCD digit per nibble, feeding the 4-digit scanned display.
REQ-009 SHALL have port Clk1, output, 1 bit: display scan clock, square wave.
REQ-010 SHALL have port Running, output, 1 bit: high in RUN or LAP.
REQ-011 SHALL have port Lap_Active, output, 1 bit: high in LAP.
REQ-012 SHALL have port Wrap, output, 1 bit: one-cycle pulse on the 59:59 to 00:00 rollover.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE and LAP.
REQ-014 IDLE SHALL go to RUN on Key_StartStop; Key_Clear and Key_Lap SHALL be ignored in IDLE.
REQ-015 RUN SHALL go to PAUSE on Key_StartStop, and to LAP on Key_Lap, capturing the live count into the lap register on the same edge.
REQ-016 LAP SHALL go to PAUSE on Key_StartStop and to RUN on Key_Lap.
REQ-017 PAUSE SHALL go to RUN on Key_StartStop, and to IDLE on Key_Clear, zeroing the count and prescaler.
REQ-018 Simultaneous key pulses SHALL resolve by priority Clear > StartStop > Lap; only the winning key SHALL act.
REQ-019 Key_Clear SHALL be ignored in RUN and LAP.
REQ-020 The prescaler SHALL count 0..SEC_DIV-1 only in RUN or LAP, hold its value in PAUSE, and be 0 in IDLE.
REQ-021 The tick SHALL occur on the edge where the prescaler equals SEC_DIV-1 while counting; the prescaler SHALL return to 0 on that edge.
REQ-022 On the tick, S0 SHALL increment 0..9; carry SHALL propagate to S1 (0..5), then M0 (0..9), then M1 (0..5).
REQ-023 On the tick at 59:59 the count SHALL become 00:00, with Wrap high for exactly that following cycle.
REQ-024 No digit SHALL ever hold a value outside its range.
REQ-025 All SHALL be registered and show the live count in IDLE, RUN and PAUSE, updating on the tick edge with zero added latency.
REQ-026 In LAP, All SHALL show the captured count while live counting continues.
REQ-027 On leaving LAP, All SHALL show the live count from the next cycle.
REQ-028 A Key_StartStop arriving on the same edge as a tick SHALL apply that tick before pausing.
REQ-029 The scan divider SHALL free-run in all states and toggle Clk1 every SCAN_DIV/2 cycles.

Reset
REQ-030 While Rst is high, the block SHALL be in IDLE with count 0, prescaler 0, scan divider 0, All 16'h0000, and Clk1, Running, Lap_Active and Wrap all 0.
REQ-031 Reset asserted mid-operation SHALL take effect immediately and asynchronously.
REQ-032 The block SHALL resume from the reset state on the first Clk edge after Rst deasserts.

Structure
REQ-033 Package stopwatch_pkg SHALL hold the state encoding and the digit limits DIG_MAX_UNITS = 9 and DIG_MAX_TENS = 5.
REQ-034 Sub-module bcd_digit_counter SHALL implement one digit: parameter MAX, inputs inc and clr, outputs digit[3:0] and carry.
REQ-035 bcd_digit_counter SHALL be instantiated four times, chained by carry.
REQ-036 The prescaler, scan divider, FSM and lap register SHALL reside in stopwatch_bcd.

Verification (SEC_DIV=4, SCAN_DIV=4)
REQ-037 Bench SHALL cover reset: Rst pulse -> All=0x0000, Clk1=0, Running=0; Clk1 then toggles every 2 cycles.
REQ-038 Bench SHALL cover counting: StartStop, then 40 cycles -> All=0x0010, Running=1; StartStop -> All holds 0x0010 across 20 cycles.
REQ-039 Bench SHALL cover wrap: run 3599 s (14396 cycles) -> All=0x5959; next tick -> All=0x0000 with a single-cycle Wrap pulse.
REQ-040 Bench SHALL cover lap: Lap at 0x0005 -> Lap_Active=1, All stays 0x0005 for 12 cycles; Lap again -> All=0x0008.
REQ-041 Bench SHALL cover key priority: in PAUSE, Clear and StartStop on the same cycle -> IDLE, All=0x0000, Running=0; Clear during RUN is ignored.
REQ-042 Bench SHALL cover mid-run reset: Rst asserted at 0x0123 between edges -> All=0x0000 immediately, and the state is IDLE after release.
